// File: rtl/pipe_csel_adder_if.sv
// Operand/result handshake bundle for the pipelined carry-select adder.
// The master side produces operands and consumes results; the adder is the slave.
interface pipe_csel_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             c_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] X;
  logic             c_out;
  logic             ovf;

  modport master (
    output in_valid, A, B, c_in, sub, out_ready,
    input  in_ready, out_valid, X, c_out, ovf
  );

  modport slave (
    input  in_valid, A, B, c_in, sub, out_ready,
    output in_ready, out_valid, X, c_out, ovf
  );
endinterface

// File: rtl/pipe_csel_adder.sv
// Pipelined carry-select adder/subtractor: one SEG_W-bit segment resolved per stage,
// with a single global enable so a stalled output freezes the whole pipe.
module pipe_csel_adder #(
  parameter int WIDTH = 32,
  parameter int SEG_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  pipe_csel_adder_if.slave  bus
);

  localparam int NSEG = WIDTH / SEG_W;

  logic en;

  assign en           = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = en;

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    // Operand bits not yet resolved when entering stage k, and result bits resolved after it.
    localparam int IN_W = WIDTH - k * SEG_W;
    localparam int LO_W = (k + 1) * SEG_W;

    logic [IN_W-1:0]  a_in;
    logic [IN_W-1:0]  b_in;
    logic             cin;
    logic             v_in;
    logic [SEG_W-1:0] a_seg;
    logic [SEG_W-1:0] b_seg;
    logic [SEG_W:0]   sum0;
    logic [SEG_W:0]   sum1;
    logic [SEG_W:0]   sel;
    logic [LO_W-1:0]  r_next;
    logic [LO_W-1:0]  r_q;
    logic             carry_q;
    logic             valid_q;

    if (k == 0) begin : g_head
      assign a_in   = bus.A;
      assign b_in   = bus.sub ? ~bus.B : bus.B;
      assign cin    = bus.sub | bus.c_in;
      assign v_in   = bus.in_valid;
      assign r_next = sel[SEG_W-1:0];
    end else begin : g_body
      assign a_in   = g_stage[k-1].g_fwd.a_q;
      assign b_in   = g_stage[k-1].g_fwd.b_q;
      assign cin    = g_stage[k-1].carry_q;
      assign v_in   = g_stage[k-1].valid_q;
      assign r_next = {sel[SEG_W-1:0], g_stage[k-1].r_q};
    end

    // Both carry hypotheses are formed up front; the registered carry only drives the mux.
    assign a_seg = a_in[SEG_W-1:0];
    assign b_seg = b_in[SEG_W-1:0];
    assign sum0  = {1'b0, a_seg} + {1'b0, b_seg};
    assign sum1  = {1'b0, a_seg} + {1'b0, b_seg} + (SEG_W+1)'(1);
    assign sel   = cin ? sum1 : sum0;

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        r_q     <= '0;
      end else if (en) begin
        valid_q <= v_in;
        carry_q <= sel[SEG_W];
        r_q     <= r_next;
      end
    end

    if (k < NSEG - 1) begin : g_fwd
      logic [IN_W-SEG_W-1:0] a_q;
      logic [IN_W-SEG_W-1:0] b_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en) begin
          a_q <= a_in[IN_W-1:SEG_W];
          b_q <= b_in[IN_W-1:SEG_W];
        end
      end
    end else begin : g_tail
      logic ovf_q;
      logic c_msb;

      // Carry into the MSB is recovered from the MSB sum bit and its two operand bits.
      assign c_msb = a_seg[SEG_W-1] ^ b_seg[SEG_W-1] ^ sel[SEG_W-1];

      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (en) begin
          ovf_q <= c_msb ^ sel[SEG_W];
        end
      end
    end
  end

  assign bus.out_valid = g_stage[NSEG-1].valid_q;
  assign bus.X         = g_stage[NSEG-1].r_q;
  assign bus.c_out     = g_stage[NSEG-1].carry_q;
  assign bus.ovf       = g_stage[NSEG-1].g_tail.ovf_q;

endmodule
